// File: rtl/mxint_pkg.sv
// Shared MxInt helpers: exponent bias, redundant-sign-bit count and the signed exponent type.
package mxint_pkg;

    // Signed exponent holds any biased exponent up to MaxExpWidth bits plus headroom for rebiasing.
    localparam int unsigned MaxExpWidth = 8;
    localparam int unsigned SExpWidth   = MaxExpWidth + 2;

    typedef logic signed [SExpWidth-1:0] sexp_t;

    function automatic int exp_bias(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Number of bits below the MSB that repeat it; an all-sign word yields width-1.
    function automatic int redundant_sign_count(input logic [63:0] mant, input int width);
        int   cnt;
        logic run;
        cnt = 0;
        run = 1'b1;
        for (int i = 62; i >= 0; i--) begin
            if (i < width - 1) begin
                if (run && (mant[6'(i)] == mant[6'(width - 1)])) begin
                    cnt++;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mxint_renormalizer_if.sv
// Valid/ready MxInt block bus: BlockSize mantissas sharing one biased exponent.
interface mxint_renormalizer_if #(
    parameter int unsigned MantWidth = 17,
    parameter int unsigned ExpWidth  = 4,
    parameter int unsigned BlockSize = 4
);
    logic [BlockSize-1:0][MantWidth-1:0] mdata;
    logic [ExpWidth-1:0]                 edata;
    logic                                valid;
    logic                                ready;

    modport master (output mdata, output edata, output valid, input ready);
    modport slave  (input mdata, input edata, input valid, output ready);
endinterface

// File: rtl/mxint_redundant_sign_count.sv
// Redundant sign-bit count of one two's-complement mantissa.
module mxint_redundant_sign_count
    import mxint_pkg::*;
#(
    parameter int unsigned Width    = 17,
    parameter int unsigned CntWidth = $clog2(Width)
) (
    input  logic [Width-1:0]    mant_i,
    output logic [CntWidth-1:0] count_o
);

    assign count_o = CntWidth'(redundant_sign_count(64'(mant_i), int'(Width)));

endmodule

// File: rtl/mxint_renormalizer.sv
// Renormalises a wide MxInt block to a narrow one in a 2-stage valid/ready pipeline.
// Optional MXINT_RENORM_ROUND_EN selects round-half-up; otherwise mantissas are truncated.
module mxint_renormalizer
    import mxint_pkg::*;
#(
    parameter int unsigned DATA_IN_0_PRECISION_0  = 17,
    parameter int unsigned DATA_IN_0_PRECISION_1  = 4,
    parameter int unsigned BLOCK_SIZE             = 4,
    parameter int unsigned DATA_OUT_0_PRECISION_0 = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1 = 4
) (
    input logic                  clk,
    input logic                  rst,
    mxint_renormalizer_if.slave  data_in_0,
    mxint_renormalizer_if.master data_out_0
);

    localparam int unsigned IW   = DATA_IN_0_PRECISION_0;
    localparam int unsigned OW   = DATA_OUT_0_PRECISION_0;
    localparam int unsigned EW   = DATA_OUT_0_PRECISION_1;
    localparam int unsigned BS   = BLOCK_SIZE;
    localparam int unsigned CntW = $clog2(IW);

    localparam int             BiasIn    = exp_bias(int'(DATA_IN_0_PRECISION_1));
    localparam int             BiasOut   = exp_bias(int'(EW));
    localparam sexp_t          BiasDelta = sexp_t'(BiasOut - BiasIn);
    localparam sexp_t          EMax      = sexp_t'((1 << EW) - 1);
    localparam logic [OW-1:0]  MaxPos    = OW'((1 << (OW - 1)) - 1);
    localparam logic [OW-1:0]  MinNeg    = OW'(1 << (OW - 1));

    if (OW > IW) begin : gen_bad_width
        $error("output mantissa width must not exceed input mantissa width");
    end
    if ((DATA_IN_0_PRECISION_1 > MaxExpWidth) || (EW > MaxExpWidth)) begin : gen_bad_exp
        $error("exponent width exceeds mxint_pkg::MaxExpWidth");
    end

    logic                    s1_adv, s2_adv;
    logic                    s1_valid_q, s2_valid_q;
    logic [BS-1:0][IW-1:0]   s1_m_q;
    logic [CntW-1:0]         s1_l_q, s1_l_d;
    sexp_t                   s1_e_q, s1_e_d;
    logic [BS-1:0][OW-1:0]   s2_m_q, s2_m_d;
    logic [EW-1:0]           s2_e_q, s2_e_d;
    logic [BS-1:0][CntW-1:0] rsc;

    assign s2_adv          = !s2_valid_q || data_out_0.ready;
    assign s1_adv          = !s1_valid_q || s2_adv;
    assign data_in_0.ready = s1_adv;

    // Stage 1: per-element sign counts, block minimum, rebiased exponent.
    for (genvar g = 0; g < BS; g++) begin : gen_rsc
        mxint_redundant_sign_count #(
            .Width   (IW),
            .CntWidth(CntW)
        ) u_rsc (
            .mant_i (data_in_0.mdata[g]),
            .count_o(rsc[g])
        );
    end

    always_comb begin
        s1_l_d = CntW'(IW - 1);
        for (int i = 0; i < int'(BS); i++) begin
            if (rsc[i] < s1_l_d) begin
                s1_l_d = rsc[i];
            end
        end
    end

    assign s1_e_d = sexp_t'(data_in_0.edata) + BiasDelta;

    // Stage 2: shift by the effective normalisation, round, and clamp the exponent range.
    sexp_t           l_ext, l_eff, e_norm;
    logic            underflow, overflow;
    logic [CntW-1:0] shamt;

    assign l_ext     = sexp_t'(s1_l_q);
    assign underflow = s1_e_q[SExpWidth-1];
    assign l_eff     = (s1_e_q < l_ext) ? s1_e_q : l_ext;
    assign e_norm    = s1_e_q - l_eff;
    assign overflow  = !underflow && (e_norm > EMax);
    assign shamt     = CntW'(l_eff);
    assign s2_e_d    = underflow ? '0 : (overflow ? EW'(EMax) : EW'(e_norm));

    for (genvar g = 0; g < BS; g++) begin : gen_out
        logic [IW-1:0] shifted;
        logic [OW-1:0] mant_hi, rounded, sat;

        assign shifted = s1_m_q[g] << shamt;
        assign mant_hi = shifted[IW-1 -: OW];
`ifdef MXINT_RENORM_ROUND_EN
        if (IW > OW) begin : gen_round
            logic half;
            assign half    = shifted[IW-OW-1];
            assign rounded = (half && (mant_hi == MaxPos)) ? MaxPos : mant_hi + OW'(half);
        end else begin : gen_exact
            assign rounded = mant_hi;
        end
`else
        assign rounded = mant_hi;
`endif
        assign sat       = s1_m_q[g][IW-1] ? MinNeg : MaxPos;
        assign s2_m_d[g] = underflow ? '0 :
                           (overflow ? ((|s1_m_q[g]) ? sat : '0) : rounded);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_m_q     <= '0;
            s1_l_q     <= '0;
            s1_e_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_m_q     <= '0;
            s2_e_q     <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= data_in_0.valid;
                if (data_in_0.valid) begin
                    s1_m_q <= data_in_0.mdata;
                    s1_l_q <= s1_l_d;
                    s1_e_q <= s1_e_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_m_q <= s2_m_d;
                    s2_e_q <= s2_e_d;
                end
            end
        end
    end

    assign data_out_0.mdata = s2_m_q;
    assign data_out_0.edata = s2_e_q;
    assign data_out_0.valid = s2_valid_q;

endmodule

// File: tb/tb_mxint_renormalizer.sv
// Self-checking bench for mxint_renormalizer: directed cases plus a randomized scoreboard run.
module tb_mxint_renormalizer;

    localparam int IW = 17;
    localparam int OW = 8;
    localparam int BS = 4;

    typedef int blk_t[BS];
    typedef struct {
        blk_t m;
        int   e;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mxint_renormalizer_if #(.MantWidth(IW), .ExpWidth(4), .BlockSize(BS)) in_if ();
    mxint_renormalizer_if #(.MantWidth(OW), .ExpWidth(4), .BlockSize(BS)) out_if ();
    mxint_renormalizer_if #(.MantWidth(IW), .ExpWidth(4), .BlockSize(BS)) in3_if ();
    mxint_renormalizer_if #(.MantWidth(OW), .ExpWidth(3), .BlockSize(BS)) out3_if ();

    mxint_renormalizer #(
        .DATA_IN_0_PRECISION_0 (IW),
        .DATA_IN_0_PRECISION_1 (4),
        .BLOCK_SIZE            (BS),
        .DATA_OUT_0_PRECISION_0(OW),
        .DATA_OUT_0_PRECISION_1(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in_0 (in_if),
        .data_out_0(out_if)
    );

    mxint_renormalizer #(
        .DATA_IN_0_PRECISION_0 (IW),
        .DATA_IN_0_PRECISION_1 (4),
        .BLOCK_SIZE            (BS),
        .DATA_OUT_0_PRECISION_0(OW),
        .DATA_OUT_0_PRECISION_1(3)
    ) dut_e3 (
        .clk       (clk),
        .rst       (rst),
        .data_in_0 (in3_if),
        .data_out_0(out3_if)
    );

    // Reference: values treated as integers; normalisation is the largest power-of-two
    // scale every element tolerates without leaving the IW-bit signed range.
    function automatic res_t ref_model(input blk_t m, input int e_in, input int ew_out);
        res_t   r;
        int     l, e, leff, k;
        longint lim, d, v, q;
        lim = longint'(1) << (IW - 1);
        d   = longint'(1) << (IW - OW);
        l   = IW - 1;
        for (int i = 0; i < BS; i++) begin
            k = 0;
            while (k < IW - 1 && longint'(m[i]) * (longint'(2) << k) < lim &&
                   longint'(m[i]) * (longint'(2) << k) >= -lim) begin
                k++;
            end
            if (k < l) l = k;
        end
        e = e_in - 7 + ((1 << (ew_out - 1)) - 1);
        if (e < 0) begin
            for (int i = 0; i < BS; i++) r.m[i] = 0;
            r.e = 0;
            return r;
        end
        leff = (l < e) ? l : e;
        r.e  = e - leff;
        for (int i = 0; i < BS; i++) begin
            v = longint'(m[i]) * (longint'(1) << leff);
`ifdef MXINT_RENORM_ROUND_EN
            v = v + d / 2;
`endif
            q = v / d;
            if ((v % d != 0) && (v < 0)) q = q - 1;
            if (q > (1 << (OW - 1)) - 1) q = (1 << (OW - 1)) - 1;
            r.m[i] = int'(q);
        end
        if (r.e > (1 << ew_out) - 1) begin
            r.e = (1 << ew_out) - 1;
            for (int i = 0; i < BS; i++) begin
                r.m[i] = (m[i] > 0) ? (1 << (OW - 1)) - 1 : ((m[i] < 0) ? -(1 << (OW - 1)) : 0);
            end
        end
        return r;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        int   sh;
        sh = int'($urandom_range(0, 16));
        for (int i = 0; i < BS; i++) begin
            b[i] = (int'($urandom_range(0, 131071)) - 65536) >>> sh;
            if ($urandom_range(0, 9) == 0) b[i] = 0;
        end
        if ($urandom_range(0, 15) == 0) begin
            for (int i = 0; i < BS; i++) b[i] = 0;
        end
        return b;
    endfunction

    function automatic logic [32*BS+31:0] pack_res(input res_t r);
        logic [32*BS+31:0] p;
        for (int i = 0; i < BS; i++) p[i*32 +: 32] = r.m[i];
        p[32*BS +: 32] = r.e;
        return p;
    endfunction

    function automatic string res_str(input res_t r);
        return $sformatf("{%0d,%0d,%0d,%0d} e=%0d", r.m[0], r.m[1], r.m[2], r.m[3], r.e);
    endfunction

    function automatic res_t read_out();
        res_t r;
        for (int i = 0; i < BS; i++) r.m[i] = int'($signed(out_if.mdata[i]));
        r.e = int'(out_if.edata);
        return r;
    endfunction

    function automatic res_t read_out3();
        res_t r;
        for (int i = 0; i < BS; i++) r.m[i] = int'($signed(out3_if.mdata[i]));
        r.e = int'(out3_if.edata);
        return r;
    endfunction

    task automatic drive_in(input blk_t m, input int e);
        for (int i = 0; i < BS; i++) in_if.mdata[i] = IW'(m[i]);
        in_if.edata = 4'(e);
        in_if.valid = 1'b1;
    endtask

    // Present one block and hold it until accepted (bounded); returns at the accepting edge + 1.
    task automatic push_one(input blk_t m, input int e, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        drive_in(m, e);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (in_if.ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_if.valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", out_if.valid);
        end
        checks++;
        if (out_if.mdata !== '0) begin
            errors++; $display("FAIL reset_mdata: got %h want 0", out_if.mdata);
        end
        checks++;
        if (out_if.edata !== 4'd0) begin
            errors++; $display("FAIL reset_edata: got %0d want 0", out_if.edata);
        end
        checks++;
        if (out3_if.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid_e3: got %b want 0", out3_if.valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", in_if.ready);
        end
    endtask

    task automatic test_normalise();
        blk_t m;
        res_t want, got;
        bit   ok;
        m = '{1024, 0, 0, -1024};
        want.m = '{64, 0, 0, -64};
        want.e = 5;
        push_one(m, 10, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL normalise_accept: got no handshake want handshake");
        end
        @(negedge clk);
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("FAIL normalise_early: got valid=%b want 0 one cycle after", out_if.valid);
        end
        @(negedge clk);
        checks++;
        if (out_if.valid !== 1'b1) begin
            errors++; $display("FAIL normalise_latency: got valid=%b want 1", out_if.valid);
        end
        got = read_out();
        checks++;
        if (pack_res(got) !== pack_res(want)) begin
            errors++; $display("FAIL normalise_data: got %s want %s", res_str(got), res_str(want));
        end
    endtask

    task automatic test_rounding();
        blk_t m[3];
        int   e[3];
        res_t want[3];
        res_t got;
        bit   ok;
        m[0] = '{33024, 0, 0, 0};       e[0] = 7;
        m[1] = '{65535, 0, 0, 0};       e[1] = 7;
        m[2] = '{33024, -33024, 0, 0};  e[2] = 15;
`ifdef MXINT_RENORM_ROUND_EN
        want[0].m = '{65, 0, 0, 0};
        want[2].m = '{65, -64, 0, 0};
`else
        want[0].m = '{64, 0, 0, 0};
        want[2].m = '{64, -65, 0, 0};
`endif
        want[1].m = '{127, 0, 0, 0};
        want[0].e = 7;  want[1].e = 7;  want[2].e = 15;
        for (int t = 0; t < 3; t++) begin
            push_one(m[t], e[t], ok);
            @(negedge clk);
            @(negedge clk);
            got = read_out();
            checks++;
            if (!ok || out_if.valid !== 1'b1 || pack_res(got) !== pack_res(want[t])) begin
                errors++;
                $display("FAIL rounding_%0d: got valid=%b %s want valid=1 %s",
                         t, out_if.valid, res_str(got), res_str(want[t]));
            end
        end
    endtask

    task automatic test_exp_limits();
        blk_t m[2];
        int   e[2];
        res_t want[2];
        res_t got;
        m[0] = '{1024, 0, 0, 0};        e[0] = 2;
        m[1] = '{33024, -33024, 0, 0};  e[1] = 15;
        want[0].m = '{0, 0, 0, 0};      want[0].e = 0;
        want[1].m = '{127, -128, 0, 0}; want[1].e = 7;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            for (int i = 0; i < BS; i++) in3_if.mdata[i] = IW'(m[t][i]);
            in3_if.edata = 4'(e[t]);
            in3_if.valid = 1'b1;
            @(posedge clk);
            #1 in3_if.valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            got = read_out3();
            checks++;
            if (out3_if.valid !== 1'b1 || pack_res(got) !== pack_res(want[t])) begin
                errors++;
                $display("FAIL exp_limit_%0d: got valid=%b %s want valid=1 %s",
                         t, out3_if.valid, res_str(got), res_str(want[t]));
            end
        end
    endtask

    task automatic test_backpressure();
        blk_t m[3];
        int   e[3];
        res_t want[3];
        res_t got;
        logic [BS*OW-1:0] snap_m;
        logic [3:0]       snap_e;
        bit   sent_c;
        int   n_got;
        for (int i = 0; i < 3; i++) begin
            m[i] = rand_blk();
            e[i] = int'($urandom_range(0, 15));
            want[i] = ref_model(m[i], e[i], 4);
        end
        out_if.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_in(m[i], e[i]);
            #1;
            checks++;
            if (in_if.ready !== 1'b1) begin
                errors++; $display("FAIL bp_accept_%0d: got ready=%b want 1", i, in_if.ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        drive_in(m[2], e[2]);
        #1;
        checks++;
        if (in_if.ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_drop: got ready=%b want 0", in_if.ready);
        end
        got = read_out();
        checks++;
        if (out_if.valid !== 1'b1 || pack_res(got) !== pack_res(want[0])) begin
            errors++; $display("FAIL bp_head: got valid=%b %s want valid=1 %s",
                               out_if.valid, res_str(got), res_str(want[0]));
        end
        snap_m = out_if.mdata;
        snap_e = out_if.edata;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_if.valid !== 1'b1 || out_if.mdata !== snap_m || out_if.edata !== snap_e ||
                in_if.ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable_%0d: got valid=%b m=%h e=%0d ready=%b want 1 %h %0d 0",
                         c, out_if.valid, out_if.mdata, out_if.edata, in_if.ready, snap_m, snap_e);
            end
        end
        sent_c = 1'b0;
        n_got  = 0;
        for (int c = 0; c < 20 && n_got < 3; c++) begin
            @(negedge clk);
            out_if.ready = 1'b1;
            if (sent_c) in_if.valid = 1'b0;
            #1;
            if (in_if.valid && in_if.ready) sent_c = 1'b1;
            if (out_if.valid) begin
                got = read_out();
                checks++;
                if (pack_res(got) !== pack_res(want[n_got])) begin
                    errors++; $display("FAIL bp_order_%0d: got %s want %s",
                                       n_got, res_str(got), res_str(want[n_got]));
                end
                n_got++;
            end
            @(posedge clk);
        end
        in_if.valid = 1'b0;
        checks++;
        if (n_got != 3) begin
            errors++; $display("FAIL bp_drain: got %0d blocks want 3", n_got);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_dup: got valid=%b want 0", out_if.valid);
        end
    endtask

    task automatic test_reset_midstream();
        blk_t a, b, x;
        res_t want, got;
        bit   ok0, ok1, ok2;
        bit   extra;
        a = rand_blk();
        b = rand_blk();
        x = '{-300, 77, 5000, 0};
        want = ref_model(x, 9, 4);
        out_if.ready = 1'b0;
        push_one(a, 3, ok0);
        push_one(b, 12, ok1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_if.valid !== 1'b0 || out_if.mdata !== '0 || out_if.edata !== 4'd0) begin
            errors++; $display("FAIL midreset_out: got valid=%b m=%h e=%0d want 0 0 0",
                               out_if.valid, out_if.mdata, out_if.edata);
        end
        checks++;
        if (in_if.ready !== 1'b1 || !ok0 || !ok1) begin
            errors++; $display("FAIL midreset_ready: got ready=%b want 1", in_if.ready);
        end
        out_if.ready = 1'b1;
        push_one(x, 9, ok2);
        @(negedge clk);
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("FAIL midreset_early: got valid=%b want 0", out_if.valid);
        end
        @(negedge clk);
        got = read_out();
        checks++;
        if (!ok2 || out_if.valid !== 1'b1 || pack_res(got) !== pack_res(want)) begin
            errors++; $display("FAIL midreset_next: got valid=%b %s want valid=1 %s",
                               out_if.valid, res_str(got), res_str(want));
        end
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_if.valid !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++; $display("FAIL midreset_ghost: got stale valid=1 want 0");
        end
    endtask

    task automatic test_random_stream();
        res_t q[$];
        res_t got, want;
        blk_t cur_m;
        int   cur_e;
        bit   pending;
        pending = 1'b0;
        cur_e   = 0;
        for (int i = 0; i < BS; i++) cur_m[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!pending && $urandom_range(0, 3) != 0) begin
                cur_m = rand_blk();
                cur_e = int'($urandom_range(0, 15));
                drive_in(cur_m, cur_e);
                pending = 1'b1;
            end else if (!pending) begin
                in_if.valid = 1'b0;
            end
            out_if.ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_if.valid && in_if.ready) begin
                q.push_back(ref_model(cur_m, cur_e, 4));
                pending = 1'b0;
            end
            if (out_if.valid && out_if.ready) begin
                got = read_out();
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious: got %s want nothing", res_str(got));
                end else begin
                    want = q.pop_front();
                    if (pack_res(got) !== pack_res(want)) begin
                        errors++; $display("FAIL rand_data: got %s want %s",
                                           res_str(got), res_str(want));
                    end
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_if.valid && q.size() != 0) begin
                got  = read_out();
                want = q.pop_front();
                checks++;
                if (pack_res(got) !== pack_res(want)) begin
                    errors++; $display("FAIL rand_drain: got %s want %s", res_str(got), res_str(want));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0 || out_if.valid !== 1'b0) begin
            errors++; $display("FAIL rand_lost: got %0d pending valid=%b want 0 0",
                               q.size(), out_if.valid);
        end
    endtask

    initial begin
        in_if.valid   = 1'b0;
        in_if.mdata   = '0;
        in_if.edata   = '0;
        out_if.ready  = 1'b1;
        in3_if.valid  = 1'b0;
        in3_if.mdata  = '0;
        in3_if.edata  = '0;
        out3_if.ready = 1'b1;
        test_reset();
        test_normalise();
        test_rounding();
        test_exp_limits();
        test_backpressure();
        test_reset_midstream();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
